// File: rtl/ps2_key_encoder_tx_if.sv
// PS/2 pad bundle between the key encoder (device side) and the pads/host.
//   ps2_clk_i   : PS/2 clock pad input (asynchronous)
//   ps2_data_i  : PS/2 data pad input (asynchronous)
//   ps2_clk_oe  : 1 = pull PS/2 clock low, 0 = release to pull-up
//   ps2_data_oe : 1 = pull PS/2 data low, 0 = release to pull-up
// master = device (drives the enables), slave = pad/host side.
interface ps2_key_encoder_tx_if;
    logic ps2_clk_i;
    logic ps2_data_i;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    modport master (
        input  ps2_clk_i,
        input  ps2_data_i,
        output ps2_clk_oe,
        output ps2_data_oe
    );

    modport slave (
        output ps2_clk_i,
        output ps2_data_i,
        input  ps2_clk_oe,
        input  ps2_data_oe
    );
endinterface

// File: rtl/ps2_key_encoder_tx.sv
// PS/2 device-side transmitter for a single key. Reports key press as the
// make code and key release as 0xF0 followed by the make code, generating
// the PS/2 clock itself and backing off whenever the host inhibits the bus.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   key_level : debounced key level, 1 = pressed
//   bus       : PS/2 pad bundle (master side), open-drain enables out
//   busy      : high in every state except IDLE
//   tx_done   : one-cycle pulse after each byte's stop bit
//   abort_cnt : host-inhibit abort count, saturating at 8'hFF
module ps2_key_encoder_tx #(
    parameter logic [7:0]  MAKE_CODE = 8'h1C,
    parameter int unsigned HALF_CYC  = 2000,
    parameter int unsigned IDLE_CYC  = 2500,
    parameter int unsigned GAP_CYC   = 4000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_level,
    ps2_key_encoder_tx_if.master        bus,
    output logic                        busy,
    output logic                        tx_done,
    output logic [7:0]                  abort_cnt
);

    localparam int unsigned QTR_CYC = HALF_CYC / 2;
    localparam int unsigned MAX_A   = (IDLE_CYC > GAP_CYC) ? IDLE_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > HALF_CYC) ? MAX_A : HALF_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned BIT_W   = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_CLKLO = 3'd3;
    localparam logic [2:0] S_CLKHI = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BIT_W-1:0] bit_idx, bit_nxt;
    logic             second, second_nxt;
    logic             two_byte, two_byte_nxt;
    logic             seq_level, seq_level_nxt;
    logic             reported, reported_nxt;
    logic [7:0]       abort_nxt;
    logic             busy_nxt, tx_done_nxt, clk_oe_nxt, data_oe_nxt;
    logic             clk_oe, data_oe;
    logic             clk_s1, clk_s2, data_s1, data_s2;
    logic [7:0]       byte_nxt;
    logic [10:0]      frame_nxt;
    logic             drive_nxt;

    assign bus.ps2_clk_oe  = clk_oe;
    assign bus.ps2_data_oe = data_oe;

    // Two-flop synchronisers for the asynchronous pad inputs (idle bus = 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= bus.ps2_clk_i;
            clk_s2  <= clk_s1;
            data_s1 <= bus.ps2_data_i;
            data_s2 <= data_s1;
        end
    end

    // Next-state, sequence bookkeeping and registered-output decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_nxt       = bit_idx;
        second_nxt    = second;
        two_byte_nxt  = two_byte;
        seq_level_nxt = seq_level;
        reported_nxt  = reported;
        abort_nxt     = abort_cnt;

        case (state)
            S_IDLE: begin
                if (key_level != reported) begin
                    state_nxt     = S_CHECK;
                    cnt_nxt       = '0;
                    two_byte_nxt  = ~key_level;
                    seq_level_nxt = key_level;
                    second_nxt    = 1'b0;
                end
            end
            S_CHECK: begin
                // A key toggle that returned to the reported level before the
                // first byte got out is dropped rather than reported.
                if (!second && (key_level == reported)) begin
                    state_nxt = S_IDLE;
                end else if (clk_s2 && data_s2) begin
                    if (cnt == CNT_W'(IDLE_CYC - 1)) begin
                        state_nxt = S_SETUP;
                        cnt_nxt   = '0;
                        bit_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            S_SETUP: begin
                if (cnt == CNT_W'(QTR_CYC - 1)) begin
                    state_nxt = S_CLKLO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CLKLO: begin
                if (cnt == CNT_W'(HALF_CYC - 1)) begin
                    state_nxt = S_CLKHI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CLKHI: begin
                // First two CLKHI cycles still see our own low clock through
                // the synchroniser; the stop bit is already committed.
                if ((bit_idx != BIT_W'(10)) && (cnt >= CNT_W'(2)) && !clk_s2) begin
                    state_nxt = S_ABORT;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(QTR_CYC - 1)) begin
                    cnt_nxt = '0;
                    if (bit_idx == BIT_W'(10)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SETUP;
                        bit_nxt   = bit_idx + BIT_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                cnt_nxt = '0;
                if (two_byte && !second) begin
                    state_nxt  = S_GAP;
                    second_nxt = 1'b1;
                end else begin
                    state_nxt    = S_IDLE;
                    reported_nxt = seq_level;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    state_nxt = S_CHECK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_ABORT: begin
                state_nxt = S_CHECK;
                cnt_nxt   = '0;
                bit_nxt   = '0;
                if (abort_cnt != 8'hFF) begin
                    abort_nxt = abort_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Frame: start 0, data LSB first, odd parity, stop 1.
        byte_nxt    = (two_byte_nxt && !second_nxt) ? 8'hF0 : MAKE_CODE;
        frame_nxt   = {1'b1, ~^byte_nxt, byte_nxt, 1'b0};
        drive_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_CLKLO) ||
                      (state_nxt == S_CLKHI);
        busy_nxt    = (state_nxt != S_IDLE);
        tx_done_nxt = (state_nxt == S_DONE);
        clk_oe_nxt  = (state_nxt == S_CLKLO);
        data_oe_nxt = drive_nxt && !frame_nxt[bit_nxt];
    end

    // State, sequence and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            second    <= 1'b0;
            two_byte  <= 1'b0;
            seq_level <= 1'b0;
            reported  <= 1'b0;
            abort_cnt <= 8'h00;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            clk_oe    <= 1'b0;
            data_oe   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            second    <= second_nxt;
            two_byte  <= two_byte_nxt;
            seq_level <= seq_level_nxt;
            reported  <= reported_nxt;
            abort_cnt <= abort_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
            clk_oe    <= clk_oe_nxt;
            data_oe   <= data_oe_nxt;
        end
    end

endmodule
